// File: rtl/cv32e41s_obi_integrity_tracker.sv
// Tracks per-transaction OBI attributes from address phase to response phase
// in a circular buffer, and flags overflow, underflow and rvalid-parity faults.
module cv32e41s_obi_integrity_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ATTR_W          = 1,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              integrity_en_i,
    input  logic              gntpar_err_i,
    input  logic              trans_integrity_i,
    input  logic              trans_we_i,
    input  logic [ATTR_W-1:0] trans_attr_i,
    input  logic              obi_req_i,
    input  logic              obi_gnt_i,
    input  logic              obi_rvalid_i,
    input  logic              obi_rvalidpar_i,
    output logic              integrity_resp_o,
    output logic              store_resp_o,
    output logic              gntpar_err_resp_o,
    output logic [ATTR_W-1:0] attr_resp_o,
    output logic [1:0]        rchk_en_o,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              full_o,
    output logic              protocol_err_o,
    output logic [2:0]        protocol_err_cause_o
);

    localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned ENTRY_W = ATTR_W + 3;

    logic [ENTRY_W-1:0] mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gntpar_err_q, gntpar_err_d;

    logic               full_c;
    logic               empty_c;
    logic               push_c;
    logic               pop_c;
    logic [ENTRY_W-1:0] wdata_c;
    logic [ENTRY_W-1:0] head_c;

    assign full_c  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty_c = (cnt_q == '0);
    // A full buffer still accepts a grant when a response frees the head slot in the same cycle.
    assign push_c  = obi_req_i && obi_gnt_i && (!full_c || obi_rvalid_i);
    assign pop_c   = obi_rvalid_i && !empty_c;
    assign wdata_c = {trans_integrity_i, trans_we_i, gntpar_err_i || gntpar_err_q, trans_attr_i};

    // Next-state for pointers, count and the sticky gnt parity error.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        gntpar_err_d = gntpar_err_q;

        if (push_c) begin
            wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PTR_W'(1);
        end

        if (push_c && !pop_c && !full_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_c && !push_c && !empty_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (obi_req_i && obi_gnt_i) begin
            gntpar_err_d = 1'b0;
        end else if (obi_req_i && gntpar_err_i) begin
            gntpar_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            gntpar_err_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            gntpar_err_q <= gntpar_err_d;
        end
    end

    // Entry storage; the only path from the bus into the buffer is the push write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wptr_q] <= wdata_c;
        end
    end

    assign head_c = empty_c ? '0 : mem_q[rptr_q];

    assign integrity_resp_o  = head_c[ENTRY_W-1];
    assign store_resp_o      = head_c[ENTRY_W-2];
    assign gntpar_err_resp_o = head_c[ENTRY_W-3];
    assign attr_resp_o       = head_c[ATTR_W-1:0];

    assign rchk_en_o[1] = obi_rvalid_i && integrity_en_i && !empty_c;
    assign rchk_en_o[0] = rchk_en_o[1] && !store_resp_o;

    assign outstanding_o = cnt_q;
    assign full_o        = full_c;

    assign protocol_err_cause_o[0] = obi_req_i && obi_gnt_i && full_c && !obi_rvalid_i;
    assign protocol_err_cause_o[1] = obi_rvalid_i && empty_c;
    assign protocol_err_cause_o[2] = integrity_en_i && (obi_rvalidpar_i == obi_rvalid_i);
    assign protocol_err_o          = |protocol_err_cause_o;

endmodule

// File: tb/tb_cv32e41s_obi_integrity_tracker.sv
// Scoreboard bench for the OBI integrity tracker (MAX_OUTSTANDING=3, ATTR_W=4).
module tb_cv32e41s_obi_integrity_tracker;

    localparam int unsigned MAX = 3;
    localparam int unsigned AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          integrity_en_i, gntpar_err_i, trans_integrity_i, trans_we_i;
    logic [AW-1:0] trans_attr_i;
    logic          obi_req_i, obi_gnt_i, obi_rvalid_i, obi_rvalidpar_i;
    logic          integrity_resp_o, store_resp_o, gntpar_err_resp_o;
    logic [AW-1:0] attr_resp_o;
    logic [1:0]    rchk_en_o;
    logic [1:0]    outstanding_o;
    logic          full_o, protocol_err_o;
    logic [2:0]    protocol_err_cause_o;

    logic [6:0]    head_obs;
    assign head_obs = {integrity_resp_o, store_resp_o, gntpar_err_resp_o, attr_resp_o};

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];
    logic [6:0] exp_head;
    logic       exp_pop;
    logic       do_push;
    logic       mdl_gpe;

    cv32e41s_obi_integrity_tracker #(.MAX_OUTSTANDING(MAX), .ATTR_W(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .integrity_en_i       (integrity_en_i),
        .gntpar_err_i         (gntpar_err_i),
        .trans_integrity_i    (trans_integrity_i),
        .trans_we_i           (trans_we_i),
        .trans_attr_i         (trans_attr_i),
        .obi_req_i            (obi_req_i),
        .obi_gnt_i            (obi_gnt_i),
        .obi_rvalid_i         (obi_rvalid_i),
        .obi_rvalidpar_i      (obi_rvalidpar_i),
        .integrity_resp_o     (integrity_resp_o),
        .store_resp_o         (store_resp_o),
        .gntpar_err_resp_o    (gntpar_err_resp_o),
        .attr_resp_o          (attr_resp_o),
        .rchk_en_o            (rchk_en_o),
        .outstanding_o        (outstanding_o),
        .full_o               (full_o),
        .protocol_err_o       (protocol_err_o),
        .protocol_err_cause_o (protocol_err_cause_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and update the expected-entry queue.
    task automatic apply(input logic req, input logic gnt, input logic rvalid, input logic bad_par,
                         input logic integ, input logic we, input logic gpe, input logic [AW-1:0] attr);
        obi_req_i         = req;
        obi_gnt_i         = gnt;
        obi_rvalid_i      = rvalid;
        obi_rvalidpar_i   = bad_par ? rvalid : !rvalid;
        trans_integrity_i = integ;
        trans_we_i        = we;
        gntpar_err_i      = gpe;
        trans_attr_i      = attr;
        #1;
        do_push  = req && gnt && ((exp_q.size() < MAX) || rvalid);
        exp_pop  = 1'b0;
        exp_head = '0;
        if (rvalid && exp_q.size() != 0) begin
            exp_head = exp_q.pop_front();
            exp_pop  = 1'b1;
        end
        if (do_push) exp_q.push_back({integ, we, gpe || mdl_gpe, attr});
        if (req && gnt) mdl_gpe = 1'b0;
        else if (req && gpe) mdl_gpe = 1'b1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        integrity_en_i = 1'b0;
        idle();
        tick();
        checks++; if (head_obs !== 7'd0) begin errors++; $display("FAIL reset_head: got %h want 00", head_obs); end
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", outstanding_o); end
        checks++; if ({full_o, protocol_err_o, protocol_err_cause_o, rchk_en_o} !== 7'd0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000", {full_o, protocol_err_o, protocol_err_cause_o, rchk_en_o});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        integrity_en_i = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1);
        checks++; if (head_obs !== 7'd0) begin errors++; $display("FAIL basic_nobypass: got %h want 00", head_obs); end
        tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
        tick();
        idle();
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL basic_cnt2: got %0d want 2", outstanding_o); end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (head_obs !== exp_head || integrity_resp_o !== 1'b1) begin errors++; $display("FAIL basic_respA: got %h want %h", head_obs, exp_head); end
        checks++; if (rchk_en_o !== 2'b11) begin errors++; $display("FAIL basic_rchkA: got %b want 11", rchk_en_o); end
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (head_obs !== exp_head || store_resp_o !== 1'b1) begin errors++; $display("FAIL basic_respB: got %h want %h", head_obs, exp_head); end
        checks++; if (rchk_en_o !== 2'b10) begin errors++; $display("FAIL basic_rchkB: got %b want 10", rchk_en_o); end
        tick();
        idle();
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL basic_cnt0: got %0d want 0", outstanding_o); end
        tick();
    endtask

    task automatic test_gntpar();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3); tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3); tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4); tick();
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            checks++; if (head_obs !== exp_head) begin errors++; $display("FAIL gntpar_resp%0d: got %h want %h", k, head_obs, exp_head); end
            checks++; if (gntpar_err_resp_o !== (k == 0)) begin errors++; $display("FAIL gntpar_bit%0d: got %b want %b", k, gntpar_err_resp_o, k == 0); end
            tick();
        end
        idle();
    endtask

    task automatic test_overflow_and_wrap();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, i[0], 1'b0, 4'(i + 8)); tick();
        end
        idle();
        checks++; if (full_o !== 1'b1 || outstanding_o !== 2'd3) begin errors++; $display("FAIL ovf_full: got full=%b cnt=%0d want full=1 cnt=3", full_o, outstanding_o); end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7);
        checks++; if (protocol_err_cause_o !== 3'b001 || protocol_err_o !== 1'b1) begin errors++; $display("FAIL ovf_cause: got %b want 001", protocol_err_cause_o); end
        tick();
        idle();
        checks++; if (protocol_err_cause_o !== 3'b000 || outstanding_o !== 2'd3) begin errors++; $display("FAIL ovf_after: got cause=%b cnt=%0d want 000/3", protocol_err_cause_o, outstanding_o); end
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0, i[1], i[0], 1'b0, 4'(i));
            checks++; if (head_obs !== exp_head || !exp_pop) begin errors++; $display("FAIL b2b_resp%0d: got %h want %h", i, head_obs, exp_head); end
            checks++; if (protocol_err_cause_o !== 3'b000) begin errors++; $display("FAIL b2b_cause%0d: got %b want 000", i, protocol_err_cause_o); end
            tick();
            checks++; if (outstanding_o !== 2'd3) begin errors++; $display("FAIL b2b_cnt%0d: got %0d want 3", i, outstanding_o); end
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            checks++; if (head_obs !== exp_head) begin errors++; $display("FAIL drain_resp%0d: got %h want %h", i, head_obs, exp_head); end
            tick();
        end
        idle();
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL drain_cnt: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_underflow_rvalidpar();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (protocol_err_cause_o !== 3'b010) begin errors++; $display("FAIL udf_cause: got %b want 010", protocol_err_cause_o); end
        checks++; if (head_obs !== 7'd0 || rchk_en_o !== 2'b00) begin errors++; $display("FAIL udf_resp: got %h/%b want 00/00", head_obs, rchk_en_o); end
        tick();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
        checks++; if (protocol_err_cause_o !== 3'b010) begin errors++; $display("FAIL udf_gnt_cause: got %b want 010", protocol_err_cause_o); end
        tick();
        idle();
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL udf_gnt_cnt: got %0d want 1", outstanding_o); end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (protocol_err_cause_o !== 3'b100) begin errors++; $display("FAIL rvp_cause: got %b want 100", protocol_err_cause_o); end
        checks++; if (head_obs !== exp_head) begin errors++; $display("FAIL rvp_resp: got %h want %h", head_obs, exp_head); end
        tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9); tick();
        integrity_en_i = 1'b0;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (protocol_err_cause_o !== 3'b000 || rchk_en_o !== 2'b00) begin errors++; $display("FAIL rvp_dis: got %b/%b want 000/00", protocol_err_cause_o, rchk_en_o); end
        checks++; if (head_obs !== exp_head) begin errors++; $display("FAIL rvp_dis_resp: got %h want %h", head_obs, exp_head); end
        tick();
        integrity_en_i = 1'b1;
        idle();
    endtask

    task automatic test_attr_random();
        logic [AW-1:0] attrs [3];
        logic [AW-1:0] a;
        int idx  = 0;
        int nret = 0;
        int cyc  = 0;
        logic g, r;
        attrs[0] = 4'hA; attrs[1] = 4'h5; attrs[2] = 4'hF;
        while (cyc < 200 && (idx < 3 || exp_q.size() != 0)) begin
            g = (idx < 3) && ($urandom_range(0, 1) == 1);
            r = (exp_q.size() != 0) && ($urandom_range(0, 2) == 0);
            a = (idx < 3) ? attrs[idx] : '0;
            apply(idx < 3, g, r, 1'b0, 1'b0, 1'b0, 1'b0, a);
            if (do_push) idx++;
            if (exp_pop) begin
                checks++; if (attr_resp_o !== exp_head[3:0] || attr_resp_o !== attrs[nret]) begin
                    errors++; $display("FAIL attr_resp%0d: got %h want %h", nret, attr_resp_o, attrs[nret]);
                end
                nret++;
            end
            tick();
            cyc++;
        end
        idle();
        checks++; if (nret != 3) begin errors++; $display("FAIL attr_timeout: got %0d responses want 3", nret); end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC); tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hD); tick();
        idle();
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL rstmid_pre: got %0d want 2", outstanding_o); end
        integrity_en_i = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl_gpe = 1'b0;
        checks++; if (outstanding_o !== 2'd0 || head_obs !== 7'd0) begin errors++; $display("FAIL rstmid_async: got cnt=%0d head=%h want 0/00", outstanding_o, head_obs); end
        tick();
        checks++; if ({full_o, protocol_err_o, protocol_err_cause_o, rchk_en_o, outstanding_o, head_obs} !== 16'd0) begin
            errors++; $display("FAIL rstmid_outs: got %h want 0", {full_o, protocol_err_o, protocol_err_cause_o, rchk_en_o, outstanding_o, head_obs});
        end
        rst_n = 1'b1;
        tick();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++; if (protocol_err_cause_o !== 3'b010 || head_obs !== 7'd0) begin errors++; $display("FAIL rstmid_udf: got %b/%h want 010/00", protocol_err_cause_o, head_obs); end
        tick();
        idle();
    endtask

    initial begin
        mdl_gpe = 1'b0;
        test_reset();
        test_basic();
        test_gntpar();
        test_overflow_and_wrap();
        test_underflow_rvalidpar();
        test_attr_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
